ext_mem_d1_host: RTL
====================

# ext_mem_d1_host

Single-port, one-dimensional memory endpoint that sits directly downstream of a generated `main` component and terminates its `memN_*` external memory ports. It supports `std_mem_d1` write/read semantics toward the component. It adds a host-side request/acknowledge port so a testbench or SoC bus can preload and dump contents, plus a sequential clear engine. Typical instance: WIDTH=4, SIZE=2, IDX_SIZE=1, backing `mem0`.

## Interface
- WIDTH, 32, data word width in bits
- SIZE, 16, number of words
- IDX_SIZE, 4, address width in bits
- clk  in  1  the single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears control state immediately
- addr0  in  IDX_SIZE  component read/write address
- write_data  in  WIDTH  component write data
- write_en  in  1  component write strobe
- read_data  out  WIDTH  combinational mem[addr0]
- done  out  1  one-cycle pulse acknowledging a component write
- host_req  in  1  host transaction request; held until host_ack
- host_we  in  1  1 = write, 0 = read; sampled with host_req
- host_addr  in  IDX_SIZE  host address
- host_wdata  in  WIDTH  host write data
- host_rdata  out  WIDTH  registered host read data
- host_ack  out  1  one-cycle host completion pulse
- clear_start  in  1  start zero-fill of all words
- clear_busy  out  1  high while the clear engine runs
- err  out  1  sticky out-of-range flag (see Configuration)

## Operation
- FSM states: IDLE, ACK, CLEAR. Reset → IDLE.
- Component port has absolute priority every cycle, in every state. If write_en=1, mem[addr0] ← write_data at the edge, and done=1 on the following cycle.
- IDLE:
  - If clear_start=1, go to CLEAR with idx=0. clear_start beats host_req.
  - Else if host_req=1 and write_en=0, accept the host transaction.
    - Write: mem[host_addr] ← host_wdata.
    - Read: host_rdata ← mem[host_addr].
    - Then go to ACK.
  - host_req with write_en=1 is deferred; it is not dropped.
- ACK: host_ack=1 for this cycle; return to IDLE. A still-asserted host_req is evaluated again in IDLE, so the maximum host rate is one transaction per 2 cycles.
- CLEAR:
  - Each cycle with write_en=0: mem[idx] ← 0 and idx++.
  - A cycle with write_en=1 stalls idx.
  - After idx reaches SIZE-1 and that word is written, return to IDLE.
  - clear_start and host_req are ignored in CLEAR.
  - A component write to an address ≥ idx during CLEAR is later overwritten with 0. This is allowed and not flagged.
- Memory array contents are not reset. They are undefined until written or cleared.

## Timing
- Reset values: done=0, host_ack=0, host_rdata=0, clear_busy=0, err=0, state=IDLE, idx=0. read_data follows the array (undefined after power-up).
- Component write latency: data is visible on read_data from the edge of commit; done rises 1 cycle after the write_en cycle.
- Host latency: host_ack rises 1 cycle after acceptance. With no contention, that is 1 cycle after host_req. host_rdata is valid in the host_ack cycle and holds until the next read.
- Clear duration: exactly SIZE cycles of clear_busy=1 with no stalls, plus 1 cycle per stall.
- Reset asserted mid-CLEAR or mid-ACK: outputs drop to reset values asynchronously; partially cleared words keep their values; a pending host transaction is lost.

## Configuration
- EXT_MEM_BOUNDS_CHECK_EN defined:
  - Any component, host or clear address ≥ SIZE suppresses that write.
  - A host read of an out-of-range address returns 0.
  - err sets 1 on the cycle after the offending access and stays set until reset.
  - done and host_ack still pulse normally.
- Not defined: no address checking; err is tied to 0; out-of-range behaviour is unspecified.

## Test plan
- Reset, then addr0=0, write_data=6, write_en=1 for 1 cycle → read_data=6 from the next cycle with addr0=0; done=1 for exactly that one cycle.
- After that write, host read of addr 0 → host_ack=1 one cycle after host_req, with host_rdata=6.
- Same cycle: host write (addr 1, data 9) and component write (addr 0, data 3) → mem[0]=3 and done pulses; the host write is accepted one cycle later and host_ack arrives 2 cycles after host_req; mem[1]=9.
- SIZE=2, clear_start for 1 cycle → clear_busy=1 for 2 cycles; then a host read of addr 0 and addr 1 returns 0 for both. With one write_en stall injected → clear_busy lasts 3 cycles.
- Assert reset during the first CLEAR cycle → clear_busy=0 and host_ack=0 immediately; FSM is in IDLE after deassert.
- With EXT_MEM_BOUNDS_CHECK_EN, SIZE=3, IDX_SIZE=2: host write to addr 3 → host_ack pulses, no word changes, err=1 and stays set until reset.

Source files
------------

// File: rtl/ext_mem_d1_host.sv
// rtl/ext_mem_d1_host.sv - std_mem_d1 endpoint with host preload/dump port and clear engine
// Optional bounds checking and sticky err flag: define EXT_MEM_BOUNDS_CHECK_EN.
module ext_mem_d1_host #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                write_en,
  output logic [WIDTH-1:0]    read_data,
  output logic                done,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [IDX_SIZE-1:0] host_addr,
  input  logic [WIDTH-1:0]    host_wdata,
  output logic [WIDTH-1:0]    host_rdata,
  output logic                host_ack,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, ACK, CLEAR} state_t;

  localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(SIZE - 1);

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    mem [SIZE];
  logic [IDX_SIZE-1:0] idx;
  logic                host_accept;
  logic                clear_step;
  logic                mem_we;
  logic                mem_commit;
  logic [IDX_SIZE-1:0] mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    host_rd_val;

  // Host is only accepted on cycles the component leaves the single write port free.
  assign host_accept = (state == IDLE) && !reset && !clear_start && host_req && !write_en;
  assign clear_step  = (state == CLEAR) && !write_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_start)      state_nxt = CLEAR;
        else if (host_accept) state_nxt = ACK;
      end
      ACK:   state_nxt = IDLE;
      CLEAR: if (clear_step && idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    host_ack   = (state == ACK);
    clear_busy = (state == CLEAR);
    mem_we     = 1'b0;
    mem_waddr  = addr0;
    mem_wdata  = write_data;
    if (write_en) begin
      mem_we = 1'b1;
    end else if (host_accept && host_we) begin
      mem_we    = 1'b1;
      mem_waddr = host_addr;
      mem_wdata = host_wdata;
    end else if (clear_step) begin
      mem_we    = 1'b1;
      mem_waddr = idx;
      mem_wdata = '0;
    end
  end

`ifdef EXT_MEM_BOUNDS_CHECK_EN
  localparam logic [IDX_SIZE:0] SIZE_EXT = (IDX_SIZE + 1)'(SIZE);

  function automatic logic in_range(input logic [IDX_SIZE-1:0] a);
    return {1'b0, a} < SIZE_EXT;
  endfunction

  logic err_q;

  assign mem_commit  = mem_we && in_range(mem_waddr);
  assign host_rd_val = in_range(host_addr) ? mem[host_addr] : '0;
  assign err         = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else if ((write_en && !in_range(addr0)) || (host_accept && !in_range(host_addr)))
      err_q <= 1'b1;
  end
`else
  assign mem_commit  = mem_we;
  assign host_rd_val = mem[host_addr];
  assign err         = 1'b0;
`endif

  // Array contents are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_commit) mem[mem_waddr] <= mem_wdata;
  end

  assign read_data = mem[addr0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done       <= 1'b0;
      host_rdata <= '0;
      idx        <= '0;
    end else begin
      done <= write_en;
      if (host_accept && !host_we) host_rdata <= host_rd_val;
      if (state == IDLE && clear_start) idx <= '0;
      else if (clear_step)              idx <= idx + 1'b1;
    end
  end

endmodule
